// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the core's ibus (fetch) and dbus (load/store)
//   request interfaces. Requests are served one at a time from a 64-bit word
//   array after a fixed latency.
//
//   Handshake: a request is taken on the clock edge that ends a cycle in
//   which its addr_ok is high. addr_ok is combinational and can only be high
//   in IDLE. data_ok is a registered one-cycle pulse, LATENCY cycles after
//   the acceptance cycle. The requester holds valid and the request fields
//   until data_ok. Once accepted, a request always completes even if valid
//   drops, except when reset is asserted first.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   ireq_valid/ireq_addr         fetch request (4-byte aligned byte address)
//   iresp_addr_ok/data_ok/data   fetch accept, response pulse, instruction
//   dreq_valid/addr/size/strobe/data
//                                data request; strobe==0 means read
//   dresp_addr_ok/data_ok/data   data accept, response pulse, 64-bit word
//   dbg_state                    current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_is_d;
  logic [AW-1:0]  r_idx;
  logic           r_hi;
  logic [7:0]     r_strobe;
  logic [63:0]    r_wdata;
  logic           r_iok;
  logic           r_dok;
  logic [31:0]    r_idata;
  logic [63:0]    r_ddata;
  logic [63:0]    r_mem [MEM_WORDS];

  logic           w_idle;
  logic           w_acc;
  logic           w_last_busy;
  logic           w_enter_resp;
  logic           w_commit;
  logic           w_t_is_d;
  logic [AW-1:0]  w_t_idx;
  logic           w_t_hi;
  logic [7:0]     w_t_strobe;
  logic [63:0]    w_t_wdata;
  logic [63:0]    w_word;
  logic           w_unused;

  assign w_idle = (r_state == S_IDLE);
  // Reset gates addr_ok so every output reads 0 while reset is held.
  assign w_acc  = w_idle & (dreq_valid | ireq_valid) & ~reset;

  assign dresp_addr_ok = w_acc & dreq_valid;
  assign iresp_addr_ok = w_acc & ~dreq_valid;

  // Fields of the transaction being serviced. With LATENCY=1 the array is
  // touched on the acceptance edge itself, so the live request is used in IDLE.
  assign w_t_is_d   = w_idle ? dreq_valid : r_is_d;
  assign w_t_idx    = w_idle ? (dreq_valid ? dreq_addr[AW+2:3] : ireq_addr[AW+2:3]) : r_idx;
  assign w_t_hi     = w_idle ? ireq_addr[2] : r_hi;
  assign w_t_strobe = w_idle ? dreq_strobe : r_strobe;
  assign w_t_wdata  = w_idle ? dreq_data : r_wdata;

  // BUSY lasts LATENCY-1 cycles; the last one is where the counter reads 1.
  assign w_last_busy  = (r_state == S_BUSY) && (r_cnt <= CW'(1));
  assign w_enter_resp = ~reset & (((LATENCY == 1) ? w_acc : 1'b0) | w_last_busy);
  assign w_commit     = w_enter_resp & w_t_is_d & (|w_t_strobe);
  assign w_word       = r_mem[w_t_idx];

  // Size code, sub-word offset bits and address bits above the array are ignored.
  assign w_unused = ^{dreq_size, ireq_addr[63:AW+3], ireq_addr[1:0],
                      dreq_addr[63:AW+3], dreq_addr[2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_d   <= 1'b0;
      r_idx    <= '0;
      r_hi     <= 1'b0;
      r_strobe <= '0;
      r_wdata  <= '0;
      r_iok    <= 1'b0;
      r_dok    <= 1'b0;
      r_idata  <= '0;
      r_ddata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_is_d   <= dreq_valid;
            r_idx    <= w_t_idx;
            r_hi     <= ireq_addr[2];
            r_strobe <= dreq_strobe;
            r_wdata  <= dreq_data;
            r_cnt    <= CW'(LATENCY - 1);
            r_state  <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_last_busy) r_state <= S_RESP;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // data_ok is high exactly while in RESP; data holds between responses.
      r_iok <= w_enter_resp & ~w_t_is_d;
      r_dok <= w_enter_resp & w_t_is_d;
      if (w_enter_resp) begin
        if (w_t_is_d) r_ddata <= w_word;
        else          r_idata <= w_t_hi ? w_word[63:32] : w_word[31:0];
      end
    end
  end

  // Store commits on the edge entering RESP; the read above sees the old word.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (w_t_strobe[b]) r_mem[w_t_idx][8*b +: 8] <= w_t_wdata[8*b +: 8];
      end
    end
  end

  assign iresp_data_ok = r_iok;
  assign dresp_data_ok = r_dok;
  assign iresp_data    = r_idata;
  assign dresp_data    = r_ddata;
  assign dbg_state     = r_state;

endmodule
